// File: rtl/pci_bus_arbiter_if.sv
// Signal bundle between the PCI arbiter and its masters.
// REQ/FRAME/IRDY flow in; GNT, OWNER and status flow out.
interface pci_bus_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int IDX_W     = 2
);
  logic [N_MASTERS-1:0] REQ;
  logic                 FRAME;
  logic                 IRDY;
  logic [N_MASTERS-1:0] GNT;
  logic [IDX_W-1:0]     OWNER;
  logic                 BUS_BUSY;
  logic                 TIMEOUT_P;

  modport slave  (input  REQ, FRAME, IRDY, output GNT, OWNER, BUS_BUSY, TIMEOUT_P);
  modport master (output REQ, FRAME, IRDY, input  GNT, OWNER, BUS_BUSY, TIMEOUT_P);
endinterface

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI central arbiter with unused-grant timeout and registered GNT.
// Bus parking on PARK_ID is built in when PCI_ARB_PARK_EN is defined.
//
// state  | meaning
// IDLE   | no grant (or parked grant), picking the next winner
// GRANT  | GNT[OWNER] low, waiting for FRAME; timeout counter running
// BUSY   | transaction in progress, GNT kept only for a sole requester
// SWITCH | one turnaround cycle with every GNT high
module pci_bus_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int IDX_W     = 2,
  parameter int TIMEOUT   = 16,
  parameter int PARK_ID   = 0
) (
  input logic              CLK_i,
  input logic              RST_i,
  pci_bus_arbiter_if.slave bus_io
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;
  localparam logic [1:0] ST_SWITCH = 2'd3;

  localparam logic [N_MASTERS-1:0] GNT_NONE = '1;
  localparam logic [7:0]           CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]           state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 tp_q, tp_d;

  logic                 bus_idle;
  logic                 any_req;
  logic                 keep_gnt;
  logic [IDX_W-1:0]     win_idx;
  logic [N_MASTERS-1:0] owner_oh;
  int                   cand;

  assign bus_idle = bus_io.FRAME & bus_io.IRDY;
  assign any_req  = ~&bus_io.REQ;
  assign owner_oh = N_MASTERS'(1) << owner_q;
  // Owner may keep its grant during a transfer only while it is the sole requester.
  assign keep_gnt = (bus_io.REQ == ~owner_oh);

  // Walk from the farthest candidate back so the one right after last_q wins.
  always_comb begin
    win_idx = '0;
    cand    = 0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      cand = (int'(last_q) + k) % N_MASTERS;
      if (!bus_io.REQ[IDX_W'(cand)]) win_idx = IDX_W'(cand);
    end
  end

`ifdef PCI_ARB_PARK_EN
  localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(PARK_ID);
  logic parked;
  assign parked = (state_q == ST_IDLE) && (gnt_q != GNT_NONE);
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    tp_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
`ifdef PCI_ARB_PARK_EN
        if (parked && !bus_io.FRAME) begin
          state_d = ST_BUSY;
          last_d  = owner_q;
          busy_d  = 1'b1;
          gnt_d   = keep_gnt ? ~owner_oh : GNT_NONE;
        end else if (parked && any_req && (win_idx != PARK_IDX)) begin
          gnt_d = GNT_NONE;
        end else if (any_req && bus_idle) begin
          state_d = ST_GRANT;
          gnt_d   = ~(N_MASTERS'(1) << win_idx);
          owner_d = win_idx;
          cnt_d   = '0;
        end else if (!any_req) begin
          gnt_d   = ~(N_MASTERS'(1) << PARK_IDX);
          owner_d = PARK_IDX;
        end
`else
        if (any_req && bus_idle) begin
          state_d = ST_GRANT;
          gnt_d   = ~(N_MASTERS'(1) << win_idx);
          owner_d = win_idx;
          cnt_d   = '0;
        end
`endif
      end
      ST_GRANT: begin
        if (!bus_io.FRAME) begin
          state_d = ST_BUSY;
          last_d  = owner_q;
          busy_d  = 1'b1;
          gnt_d   = keep_gnt ? ~owner_oh : GNT_NONE;
        end else if (bus_io.REQ[owner_q]) begin
          state_d = ST_SWITCH;
          gnt_d   = GNT_NONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_SWITCH;
          gnt_d   = GNT_NONE;
          tp_d    = 1'b1;
          last_d  = owner_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_BUSY: begin
        if (bus_idle) begin
          state_d = ST_SWITCH;
          busy_d  = 1'b0;
          gnt_d   = GNT_NONE;
        end else if (!keep_gnt) begin
          gnt_d = GNT_NONE;
        end
      end
      ST_SWITCH: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_NONE;
      owner_q <= '0;
      last_q  <= IDX_W'(N_MASTERS - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      tp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      tp_q    <= tp_d;
    end
  end

  assign bus_io.GNT       = gnt_q;
  assign bus_io.OWNER     = owner_q;
  assign bus_io.BUS_BUSY  = busy_q;
  assign bus_io.TIMEOUT_P = tp_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter: directed scenarios plus random masters, scored
// against a cycle model of the arbitration rules (park rules when PCI_ARB_PARK_EN).
module tb_pci_bus_arbiter;
  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int TO   = 16;
  localparam int PARK = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  pci_bus_arbiter_if #(.N_MASTERS(N), .IDX_W(IW)) bus ();

  pci_bus_arbiter #(.N_MASTERS(N), .IDX_W(IW), .TIMEOUT(TO), .PARK_ID(PARK)) dut (
    .CLK_i (CLK),
    .RST_i (RST),
    .bus_io(bus)
  );

  always #5 CLK = ~CLK;

  logic [N-1:0] req_r   = '1;
  logic         frame_r = 1'b1;
  logic         irdy_r  = 1'b1;
  assign bus.REQ   = req_r;
  assign bus.FRAME = frame_r;
  assign bus.IRDY  = irdy_r;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [IW-1:0] owner;
    logic          busy;
    logic          tp;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {PH_FREE, PH_OFFERED, PH_INUSE, PH_TURN} ph_e;
  ph_e    m_ph;
  int     m_grantee;   // master whose GNT is low, -1 for none
  int     m_owner;
  int     m_last;
  bit     m_busy;
  bit     m_tp;
  longint m_cyc;
  longint m_gcyc;      // cycle on which the current offer was made

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    int p;
    for (int k = 1; k <= N; k++) begin
      p = (last + k) % N;
      if (req[p[IW-1:0]] == 1'b0) return p;
    end
    return -1;
  endfunction

  function automatic bit only_owner(input logic [N-1:0] req, input int o);
    for (int i = 0; i < N; i++)
      if ((req[i] == 1'b0) != (i == o)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_ph = PH_FREE; m_grantee = -1; m_owner = 0; m_last = N - 1;
    m_busy = 1'b0; m_tp = 1'b0; m_cyc = 0; m_gcyc = 0;
  endtask

  task automatic m_offer(input int w);
    m_ph = PH_OFFERED; m_grantee = w; m_owner = w; m_gcyc = m_cyc;
  endtask

  task automatic m_step(input logic [N-1:0] req, input logic frame, input logic irdy);
    bit idle;
    bit any;
    int win;
    idle = frame && irdy;
    any  = (req != '1);
    win  = rr_pick(req, m_last);
    m_cyc++;
    m_tp = 1'b0;
    case (m_ph)
      PH_FREE: begin
`ifdef PCI_ARB_PARK_EN
        if (m_grantee == PARK && !frame) begin
          m_ph = PH_INUSE; m_last = PARK; m_busy = 1'b1;
          if (!only_owner(req, PARK)) m_grantee = -1;
        end else if (m_grantee == PARK && any && win != PARK) begin
          m_grantee = -1;
        end else if (any && idle) begin
          m_offer(win);
        end else if (!any) begin
          m_grantee = PARK; m_owner = PARK;
        end
`else
        if (any && idle) m_offer(win);
`endif
      end
      PH_OFFERED: begin
        if (!frame) begin
          m_ph = PH_INUSE; m_last = m_owner; m_busy = 1'b1;
          if (!only_owner(req, m_owner)) m_grantee = -1;
        end else if (req[m_owner[IW-1:0]]) begin
          m_ph = PH_TURN; m_grantee = -1;
        end else if (m_cyc - m_gcyc == TO) begin
          m_ph = PH_TURN; m_grantee = -1; m_tp = 1'b1; m_last = m_owner;
        end
      end
      PH_INUSE: begin
        if (idle) begin
          m_ph = PH_TURN; m_busy = 1'b0; m_grantee = -1;
        end else if (!only_owner(req, m_owner)) begin
          m_grantee = -1;
        end
      end
      default: begin
        m_ph = PH_FREE; m_grantee = -1;
      end
    endcase
  endtask

  function automatic exp_t cur_exp();
    exp_t e;
    e.gnt = '1;
    if (m_grantee >= 0) e.gnt[m_grantee[IW-1:0]] = 1'b0;
    e.owner = m_owner[IW-1:0];
    e.busy  = m_busy;
    e.tp    = m_tp;
    return e;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_reset();
      exp_q.delete();
      exp_q.push_back(cur_exp());
    end else begin
      m_step(req_r, frame_r, irdy_r);
      exp_q.push_back(cur_exp());
    end
  end

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty actual=none required=entry at %0t", $time);
      end else begin
        cur = exp_q.pop_front();
        chk("sb_gnt",   32'(bus.GNT),       32'(cur.gnt));
        chk("sb_owner", 32'(bus.OWNER),     32'(cur.owner));
        chk("sb_busy",  32'(bus.BUS_BUSY),  32'(cur.busy));
        chk("sb_tp",    32'(bus.TIMEOUT_P), 32'(cur.tp));
      end
      chk("one_gnt_low", 32'($countones(~bus.GNT) <= 1), 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_grant(output int who);
    who = -1;
    for (int t = 0; t < 20 && who < 0; t++) begin
      if (bus.GNT != '1) begin
        for (int i = 0; i < N; i++) if (bus.GNT[i] == 1'b0) who = i;
      end else begin
        step();
      end
    end
    if (who < 0) begin
      checks++;
      failures++;
      $display("FAIL wait_grant actual=no_grant required=grant within 20 cycles at %0t", $time);
    end
  endtask

  task automatic xfer(input int phases);
    frame_r = 1'b0; irdy_r = 1'b0;
    repeat (phases - 1) step();
    frame_r = 1'b1;
    step();
    irdy_r = 1'b1;
    step();
  endtask

  initial begin
    int who;
    int lowc;
    int xl;
    bit was_idle;

    repeat (3) step();
    mon_en = 1'b1;
    chk("rst_gnt",   32'(bus.GNT),       32'hF);
    chk("rst_owner", 32'(bus.OWNER),     32'd0);
    chk("rst_busy",  32'(bus.BUS_BUSY),  32'd0);
    chk("rst_tp",    32'(bus.TIMEOUT_P), 32'd0);
    RST = 1'b0;

`ifndef PCI_ARB_PARK_EN
    repeat (3) step();
    chk("idle_gnt", 32'(bus.GNT), 32'hF);

    // round robin, everyone requesting
    req_r = '0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(who);
      chk("rr_order", 32'(who), 32'(i % N));
      chk("rr_owner", 32'(bus.OWNER), 32'(i % N));
      if (i < 4) xfer(3);
    end
    req_r = '1;
    repeat (4) step();

    // single master
    req_r = 4'b1101;
    step();
    chk("single_gnt", 32'(bus.GNT), 32'hD);
    chk("single_owner", 32'(bus.OWNER), 32'd1);
    frame_r = 1'b0; irdy_r = 1'b0;
    step();
    chk("single_busy", 32'(bus.BUS_BUSY), 32'd1);
    chk("single_busy_gnt", 32'(bus.GNT), 32'hD);
    frame_r = 1'b1;
    step();
    chk("single_last_phase", 32'(bus.BUS_BUSY), 32'd1);
    irdy_r = 1'b1; req_r = '1;
    step();
    chk("single_switch_gnt", 32'(bus.GNT), 32'hF);
    chk("single_switch_busy", 32'(bus.BUS_BUSY), 32'd0);
    step();

    // preemption
    req_r = 4'b1101;
    wait_grant(who);
    chk("pre_who", 32'(who), 32'd1);
    frame_r = 1'b0; irdy_r = 1'b0;
    step();
    chk("pre_busy_gnt", 32'(bus.GNT), 32'hD);
    req_r = 4'b0101;
    step();
    chk("pre_drop", 32'(bus.GNT), 32'hF);
    chk("pre_still_busy", 32'(bus.BUS_BUSY), 32'd1);
    frame_r = 1'b1;
    step();
    irdy_r = 1'b1; req_r = 4'b0111;
    step();
    chk("pre_switch", 32'(bus.GNT), 32'hF);
    chk("pre_switch_busy", 32'(bus.BUS_BUSY), 32'd0);
    step();
    chk("pre_idle", 32'(bus.GNT), 32'hF);
    step();
    chk("pre_next", 32'(bus.GNT), 32'h7);
    req_r = '1;
    repeat (3) step();

    // unused grant timeout
    lowc = 0;
    req_r = 4'b1110;
    for (int i = 0; i < TO; i++) begin
      step();
      if (bus.GNT == 4'b1110 && !bus.TIMEOUT_P) lowc++;
    end
    chk("to_hold_cycles", 32'(lowc), 32'(TO));
    step();
    chk("to_pulse", 32'(bus.TIMEOUT_P), 32'd1);
    chk("to_gnt_drop", 32'(bus.GNT), 32'hF);
    req_r = 4'b1100;
    step();
    chk("to_pulse_once", 32'(bus.TIMEOUT_P), 32'd0);
    step();
    chk("to_next", 32'(bus.GNT), 32'hD);
    req_r = '1;
    repeat (3) step();

    // asynchronous reset in the middle of a transfer
    req_r = 4'b1110;
    wait_grant(who);
    frame_r = 1'b0; irdy_r = 1'b0;
    step();
    chk("rst_mid_gnt_before", 32'(bus.GNT), 32'hE);
    #1 RST = 1'b1;
    #1;
    chk("rst_mid_gnt", 32'(bus.GNT), 32'hF);
    chk("rst_mid_owner", 32'(bus.OWNER), 32'd0);
    chk("rst_mid_busy", 32'(bus.BUS_BUSY), 32'd0);
    step();
    RST = 1'b0; frame_r = 1'b1; irdy_r = 1'b1; req_r = '1;
    repeat (3) step();
    chk("rst_after_gnt", 32'(bus.GNT), 32'hF);
`else
    step();
    chk("park_gnt", 32'(bus.GNT), 32'hB);
    chk("park_owner", 32'(bus.OWNER), 32'(PARK));
    req_r = 4'b1110;
    step();
    chk("park_drop", 32'(bus.GNT), 32'hF);
    step();
    chk("park_next", 32'(bus.GNT), 32'hE);
    req_r = '1;
    repeat (4) step();
`endif

    // random masters
    xl = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        RST = 1'b1; xl = 0; frame_r = 1'b1; irdy_r = 1'b1;
        step();
        step();
        RST = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(23) == 0) req_r[i] = ~req_r[i];
      if (xl > 1) begin
        frame_r = 1'b0; irdy_r = 1'b0; xl--;
      end else if (xl == 1) begin
        frame_r = 1'b1; irdy_r = 1'b0; xl = 0;
      end else begin
        was_idle = frame_r && irdy_r;
        frame_r = 1'b1; irdy_r = 1'b1;
        if (was_idle && bus.GNT != '1 && $urandom_range(5) == 0) begin
          frame_r = 1'b0; irdy_r = 1'b0; xl = $urandom_range(1, 4);
        end
      end
      step();
    end

    req_r = '1; frame_r = 1'b1; irdy_r = 1'b1;
    repeat (5) step();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
